// File: rtl/add_mul_comp_seq.sv
// Handshaked arithmetic unit: adds in one cycle, or multiplies by iterative shift-add over WIDTH cycles.
// Compare-select mode picks add when A > B and multiply otherwise.
module add_mul_comp_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 op_mul,
   output logic                 a_gt_b
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [2*WIDTH-1:0]  r_acc;
   logic [2*WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [CW-1:0]       r_cnt;
   logic [2*WIDTH-1:0]  r_result;
   logic                r_opMul;
   logic                r_aGtB;
   logic                r_pendGt;

   logic                w_aGtB;
   logic                w_selMul;
   logic [2*WIDTH-1:0]  w_sum;
   logic [2*WIDTH-1:0]  w_partial;
   logic [2*WIDTH-1:0]  w_accNext;

   // Modes 00 and 11 have equal bits and both mean compare-select.
   assign w_aGtB    = (a > b);
   assign w_selMul  = (mode == 2'b10) | ((mode[0] == mode[1]) & ~w_aGtB);
   assign w_sum     = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
   assign w_partial = r_mplier[0] ? r_mcand : '0;
   assign w_accNext = r_acc + w_partial;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign op_mul    = r_opMul;
   assign a_gt_b    = r_aGtB;

   // Visible outputs change only when an operation completes; the compare flag
   // of a product waits in r_pendGt until the last multiply step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_opMul  <= 1'b0;
         r_aGtB   <= 1'b0;
         r_pendGt <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_selMul) begin
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_cnt    <= '0;
                     r_pendGt <= w_aGtB;
                     r_state  <= S_MUL;
                  end else begin
                     r_result <= w_sum;
                     r_opMul  <= 1'b0;
                     r_aGtB   <= w_aGtB;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_accNext;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_result <= w_accNext;
                  r_opMul  <= 1'b1;
                  r_aGtB   <= r_pendGt;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/add_mul_comp_seq.md
ADD_MUL_COMP_SEQ -- requirements
Module: add_mul_comp_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set on a, b and mode is valid.
REQ-005 Port: in_ready  output  1  block can accept a new operand set.
REQ-006 Port: a  input  WIDTH  unsigned operand A.
REQ-007 Port: b  input  WIDTH  unsigned operand B.
REQ-008 Port: mode  input  2  operation select: 00 compare-select, 01 force add, 10 force multiply, 11 reserved (treated as 00).
REQ-009 Port: out_valid  output  1  result, op_mul and a_gt_b are valid.
REQ-010 Port: out_ready  input  1  downstream accepts the result.
REQ-011 Port: result  output  2*WIDTH  unsigned result.
REQ-012 Port: op_mul  output  1  1 = result is a product, 0 = result is a sum.
REQ-013 Port: a_gt_b  output  1  registered unsigned compare flag, A > B.

Function
REQ-014 An input transfer occurs on a rising edge with in_valid=1 and in_ready=1; a, b and mode are captured in that cycle only.
REQ-015 An output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-016 FSM states: IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 Operation select: mode 01 selects add; mode 10 selects multiply; modes 00 and 11 select add when A > B, multiply otherwise (A <= B, including A == B).
REQ-018 a_gt_b is computed from the captured operands for every mode.
REQ-019 Add: result = zero-extended A + B with the carry in bit WIDTH and upper bits zero; IDLE -> DONE on the accepting edge; out_valid rises 1 cycle after acceptance.
REQ-020 Multiply: iterative shift-add, one multiplier bit per cycle, LSB first; IDLE -> MUL on the accepting edge; MUL runs exactly WIDTH cycles, then -> DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 Product is exact: result = A*B modulo 2^(2*WIDTH), with no overflow possible.
REQ-022 Multiply by zero still takes the full WIDTH cycles; there is no early exit.
REQ-023 In DONE, result, op_mul and a_gt_b are held stable while out_ready=0, for any stall length.
REQ-024 DONE -> IDLE on the output transfer edge; in_ready is 1 the following cycle; no same-cycle in/out overlap (throughput at most one operation per latency+1 cycles).
REQ-025 in_valid, a, b and mode changes while not in IDLE are ignored and do not affect the operation in flight.
REQ-026 result, op_mul and a_gt_b are don't-care-free: outside DONE they hold their last value, or reset values if no operation has completed.

Reset
REQ-027 rst_n=0 asynchronously forces state IDLE, in_ready=1, out_valid=0, result=0, op_mul=0, a_gt_b=0, and clears the internal accumulator and counter.
REQ-028 Reset asserted mid-MUL or in DONE aborts the operation; no result is emitted after release.
REQ-029 After rst_n deasserts, the first input transfer is possible on the first rising edge.

Verification
REQ-030 WIDTH=4, mode=00, A=9, B=3 -> after 1 cycle: out_valid=1, result=12, op_mul=0, a_gt_b=1.
REQ-031 WIDTH=4, mode=00, A=15, B=15 -> after 5 cycles: result=225, op_mul=1, a_gt_b=0; with out_ready held 0 for 10 cycles, outputs stay unchanged.
REQ-032 WIDTH=4, mode=01, A=15, B=15 -> result=30, op_mul=0; mode=10, A=2, B=0 -> after 5 cycles: result=0, op_mul=1, a_gt_b=1.
REQ-033 WIDTH=8, mode=10, A=255, B=255 -> after 9 cycles: result=65025; in_ready=0 throughout, and inputs toggled during MUL do not affect the result.
REQ-034 rst_n pulsed low during MUL cycle 2 -> out_valid stays 0, in_ready=1 immediately; the next operation A=3, B=5, mode=00 gives result=15.
REQ-035 Randomised, WIDTH in {2, 4, 8, 16}, random out_ready back-pressure, checked against a reference model: every transfer matches REQ-017 to REQ-021 and no operation is lost or duplicated.
